// File: rtl/kogge_stone_subtractor.sv
// Pipelined unsigned subtractor (diff = a - b) built on a Kogge-Stone carry network.
// Optional borrow_in port enabled by defining KS_SUBTRACTOR_BORROW_IN_EN.
module kogge_stone_subtractor #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef KS_SUBTRACTOR_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int SPAN   = 1 << HEIGHT;
    localparam int LAST   = 1 << (HEIGHT - 1);
    localparam int TOP_LO = WIDTH - LAST;

    // Index 0 of each group vector is the carry-in position (bit -1); bit i lives at i+1.
    logic [HEIGHT-1:0]            vld_q;
    logic [HEIGHT-1:0][WIDTH:0]   gg_q, gg_d;
    logic [HEIGHT-1:0][WIDTH:0]   pp_q, pp_d;
    logic [HEIGHT-1:0][WIDTH-1:0] p_q;

    logic [WIDTH-1:0] bit_p;
    logic             cin;
    logic [WIDTH-1:0] fin_c;
    logic             top_g;
    logic             carry_msb;
    logic             stall;
    logic             advance;

    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

`ifdef KS_SUBTRACTOR_BORROW_IN_EN
    assign cin = ~borrow_in;
`else
    assign cin = 1'b1;
`endif

    assign stall    = out_valid_q & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    // Stage 0 inputs: a + ~b + cin
    assign bit_p    = a ^ ~b;
    assign gg_d[0]  = {a & ~b, cin};
    assign pp_d[0]  = {bit_p, 1'b0};

    for (genvar k = 1; k < HEIGHT; k++) begin : g_level
        localparam int DIST = 1 << (k - 1);
        for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
            if (j >= DIST) begin : g_op
                assign gg_d[k][j] = gg_q[k-1][j] | (pp_q[k-1][j] & gg_q[k-1][j-DIST]);
                assign pp_d[k][j] = pp_q[k-1][j] & pp_q[k-1][j-DIST];
            end else begin : g_pass
                assign gg_d[k][j] = gg_q[k-1][j];
                assign pp_d[k][j] = pp_q[k-1][j];
            end
        end
    end

    // Last prefix level folds straight into the output register; only G is needed.
    for (genvar j = 0; j < WIDTH; j++) begin : g_final
        if (j >= LAST) begin : g_op
            assign fin_c[j] = gg_q[HEIGHT-1][j] |
                              (pp_q[HEIGHT-1][j] & gg_q[HEIGHT-1][j-LAST]);
        end else begin : g_pass
            assign fin_c[j] = gg_q[HEIGHT-1][j];
        end
    end

    assign top_g = gg_q[HEIGHT-1][WIDTH] |
                   (pp_q[HEIGHT-1][WIDTH] & gg_q[HEIGHT-1][TOP_LO]);

    // At a power-of-two width the MSB group still misses the carry-in after the last level.
    if (WIDTH == SPAN) begin : g_msb_fold
        assign carry_msb = top_g |
                           (pp_q[HEIGHT-1][WIDTH] & pp_q[HEIGHT-1][TOP_LO] & gg_q[HEIGHT-1][0]);
    end else begin : g_msb_done
        assign carry_msb = top_g;
    end

    assign diff_d   = p_q[HEIGHT-1] ^ fin_c;
    assign borrow_d = ~carry_msb;

    logic unused_pp;
    assign unused_pp = ^pp_q[HEIGHT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            gg_q  <= '0;
            pp_q  <= '0;
            p_q   <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            p_q[0]   <= bit_p;
            gg_q     <= gg_d;
            pp_q     <= pp_d;
            for (int k = 1; k < HEIGHT; k++) begin
                vld_q[k] <= vld_q[k-1];
                p_q[k]   <= p_q[k-1];
            end
        end
    end

    // Result registers keep their last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else if (advance) begin
            out_valid_q <= vld_q[HEIGHT-1];
            if (vld_q[HEIGHT-1]) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_kogge_stone_subtractor.sv
// Self-checking bench for kogge_stone_subtractor (WIDTH=8): directed vector table,
// streaming, stall, fill/drain and mid-flight reset sequences.
module tb_kogge_stone_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             bi_drv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    always #5 clk = ~clk;

    kogge_stone_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
`ifdef KS_SUBTRACTOR_BORROW_IN_EN
        .borrow_in  (bi_drv),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bi;
        logic [WIDTH-1:0] d;
        logic             bo;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb[$];
    int   n_emit   = 0;
    int   cur_run  = 0;
    int   best_run = 0;
    logic stalled_prev = 1'b0;
    res_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic bi);
        logic [WIDTH:0] r;
        r = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
        return {r[WIDTH-1:0], r[WIDTH]};
    endfunction

    // Scoreboard monitor: everything is stable at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stalled_prev = 1'b0;
            cur_run      = 0;
            check("reset out_valid", {31'b0, out_valid}, 32'd0);
            check("reset in_ready", {31'b0, in_ready}, 32'd1);
        end else begin
            check("in_ready rule", {31'b0, in_ready}, {31'b0, ~(out_valid & ~out_ready)});
            if (stalled_prev) begin
                check("stall valid hold", {31'b0, out_valid}, 32'd1);
                check("stall data hold", {23'b0, diff, borrow_out}, {23'b0, held});
            end
            if (out_valid && out_ready) begin
                n_emit++;
                cur_run++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected output: got %0h/%0b, expected none", diff, borrow_out);
                end else begin
                    check("stream result", {23'b0, diff, borrow_out}, {23'b0, sb.pop_front()});
                end
            end else begin
                cur_run = 0;
            end
            if (cur_run > best_run) best_run = cur_run;
            if (in_valid && in_ready) sb.push_back(model(a, b, bi_drv));
            stalled_prev = out_valid && !out_ready;
            held         = {diff, borrow_out};
        end
    end

    // Present one operand pair and return just after the edge that accepts it.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        logic acc;
        a        = x;
        b        = y;
        bi_drv   = bi;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send timeout: got no accept, expected accept within 200 cycles");
    endtask

    task automatic run_single(input vec_t v, input string tag);
        int cyc;
        send(v.a, v.b, v.bi);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, 32'd4);
        check({tag, " diff"}, {24'b0, diff}, {24'b0, v.d});
        check({tag, " borrow"}, {31'b0, borrow_out}, {31'b0, v.bo});
        @(posedge clk);
        #1;
        check({tag, " valid drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, " diff hold"}, {24'b0, diff}, {24'b0, v.d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   emit0;

        vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0});
        vecs.push_back('{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1});
        vecs.push_back('{8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0});
        vecs.push_back('{8'h01, 8'h80, 1'b0, 8'h81, 1'b1});
        vecs.push_back('{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0});
`ifdef KS_SUBTRACTOR_BORROW_IN_EN
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{8'h10, 8'h0F, 1'b0, 8'h01, 1'b0});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bi_drv    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset diff", {24'b0, diff}, 32'd0);
        check("reset borrow", {31'b0, borrow_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset out_valid", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_single(vecs[i], $sformatf("vec%0d", i));

        // 16 back-to-back pairs must leave as 16 consecutive results.
        emit0    = n_emit;
        best_run = 0;
        for (int i = 0; i < 16; i++)
            send(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 1'b0);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("stream count", n_emit - emit0, 32'd16);
        check("stream back-to-back", best_run, 32'd16);

        // Random backpressure: nothing lost or duplicated.
        emit0 = n_emit;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 100; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("backpressure count", n_emit - emit0, 32'd24);
        check("backpressure drained", sb.size(), 32'd0);

        // Fill with the output blocked, then drain.
        out_ready = 1'b0;
        emit0     = n_emit;
        send(8'h20, 8'h01, 1'b0);
        send(8'h01, 8'h20, 1'b0);
        send(8'h77, 8'h77, 1'b0);
        send(8'hC0, 8'h3F, 1'b0);
        check("fill out_valid", {31'b0, out_valid}, 32'd1);
        check("fill in_ready", {31'b0, in_ready}, 32'd0);
        a = 8'hEE;
        b = 8'h11;
        repeat (2) @(posedge clk);
        #1;
        check("stalled in_ready", {31'b0, in_ready}, 32'd0);
        check("stalled diff", {24'b0, diff}, 32'h1F);
        in_valid  = 1'b0;
        best_run  = 0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain count", n_emit - emit0, 32'd4);
        check("drain back-to-back", best_run, 32'd4);

        // Reset with three results in flight.
        send(8'h09, 8'h02, 1'b0);
        send(8'h08, 8'h03, 1'b0);
        send(8'h07, 8'h04, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", {31'b0, out_valid}, 32'd0);
        check("async reset diff", {24'b0, diff}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        emit0 = n_emit;
        repeat (8) @(posedge clk);
        #1;
        check("no stale result", n_emit - emit0, 32'd0);
        run_single('{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0}, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
